// File: rtl/countdown_pkg.sv
// Shared types, limits and divider-rate constants for the countdown timer
// controller. The package has no ports. It provides the state encoding, the
// mm:ss payload struct and the wrap-aware +/-1 s time helpers.
package countdown_pkg;

  localparam int unsigned FRE_W   = 26;
  localparam int unsigned MIN_W   = 7;
  localparam int unsigned SEC_W   = 6;
  localparam int unsigned ST_W    = 3;

  localparam int unsigned MIN_MAX = 99;
  localparam int unsigned SEC_MAX = 59;

  localparam int unsigned FRE_RUN     = 1;
  localparam int unsigned FRE_REP0    = 4;
  localparam int unsigned FRE_MAX     = 32;
  localparam int unsigned ACCEL_STEPS = 8;
  localparam int unsigned DEF_MIN     = 5;
  localparam int unsigned DEF_SEC     = 0;
  localparam int unsigned ALARM_TICKS = 30;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_SET   = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_ALARM = 3'd4
  } state_t;

  typedef struct packed {
    logic [MIN_W-1:0] mm;
    logic [SEC_W-1:0] ss;
  } mmss_t;

  localparam mmss_t DEF_TIME = '{mm: MIN_W'(DEF_MIN), ss: SEC_W'(DEF_SEC)};

  // +1 s with carry into minutes; 99:59 wraps to 00:00
  function automatic mmss_t mmss_inc(mmss_t t);
    mmss_t r;
    r = t;
    if (t.ss == SEC_W'(SEC_MAX)) begin
      r.ss = '0;
      r.mm = (t.mm == MIN_W'(MIN_MAX)) ? '0 : t.mm + MIN_W'(1);
    end else begin
      r.ss = t.ss + SEC_W'(1);
    end
    return r;
  endfunction

  // -1 s with borrow from minutes; 00:00 wraps to 99:59
  function automatic mmss_t mmss_dec(mmss_t t);
    mmss_t r;
    r = t;
    if (t.ss == '0) begin
      r.ss = SEC_W'(SEC_MAX);
      r.mm = (t.mm == '0) ? MIN_W'(MIN_MAX) : t.mm - MIN_W'(1);
    end else begin
      r.ss = t.ss - SEC_W'(1);
    end
    return r;
  endfunction

  function automatic logic mmss_zero(mmss_t t);
    return (t.mm == '0) && (t.ss == '0);
  endfunction

endpackage

// File: rtl/btn_repeat.sv
// Auto-repeat engine for the set buttons. It turns a press/hold of a single
// direction into step pulses and produces the accelerating divider target.
//   clk, rst    - clock, async active-high reset
//   i_en        - controller is in SET
//   i_held      - exactly one direction button is held (up ^ down)
//   i_press     - registered press pulse of a direction button
//   i_tick      - registered divider tick pulse
//   o_step_c    - combinational one-step pulse for this cycle
//   o_fre_tgt   - target divider rate while held (registered)
module btn_repeat
  import countdown_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_held,
  input  logic             i_press,
  input  logic             i_tick,
  output logic             o_step_c,
  output logic [FRE_W-1:0] o_fre_tgt
);

  localparam int unsigned CNT_W = $clog2(ACCEL_STEPS + 1);

  logic             w_active;
  logic             w_repeat;
  logic [CNT_W-1:0] r_cnt;
  logic [FRE_W-1:0] r_fre;

  assign w_active  = i_en & i_held;
  // A tick that coincides with the initial press is not a repeat step
  assign w_repeat  = w_active & i_tick & ~i_press;
  assign o_step_c  = w_active & (i_press | i_tick);
  assign o_fre_tgt = r_fre;

  // Repeat step counter; every ACCEL_STEPS repeats the rate doubles up to FRE_MAX
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_fre <= FRE_W'(FRE_REP0);
    end else if (!w_active) begin
      r_cnt <= '0;
      r_fre <= FRE_W'(FRE_REP0);
    end else if (w_repeat) begin
      if (r_cnt == CNT_W'(ACCEL_STEPS - 1)) begin
        r_cnt <= '0;
        r_fre <= (r_fre >= FRE_W'(FRE_MAX / 2)) ? FRE_W'(FRE_MAX)
                                                 : {r_fre[FRE_W-2:0], 1'b0};
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/countdown_ctrl.sv
// Countdown timer mode controller: owns the mm:ss value, sequences
// IDLE/SET/RUN/PAUSE/ALARM and drives the shared divider rate select.
//   clk, rst                 - clock, async active-high reset
//   tick_clk                 - divider output (same clock domain)
//   btn_set/start/up/down    - debounced button levels
//   fre                      - divider rate select
//   min, sec                 - current time
//   state                    - current state code
//   alarm                    - high while in ALARM
module countdown_ctrl
  import countdown_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_clk,
  input  logic             btn_set,
  input  logic             btn_start,
  input  logic             btn_up,
  input  logic             btn_down,
  output logic [FRE_W-1:0] fre,
  output logic [MIN_W-1:0] min,
  output logic [SEC_W-1:0] sec,
  output logic [ST_W-1:0]  state,
  output logic             alarm
);

  localparam int unsigned ACNT_W = $clog2(ALARM_TICKS + 1);

  logic r_tick_q, r_tick, r_tog;
  logic r_set_q, r_start_q, r_up_q, r_dn_q;
  logic r_set_p, r_start_p, r_up_p, r_dn_p;

  state_t            r_state;
  mmss_t             r_time;
  mmss_t             r_pre;
  logic              r_alarm;
  logic [ACNT_W-1:0] r_acnt;
  logic [FRE_W-1:0]  r_fre;

  logic             w_held;
  logic             w_step;
  logic             w_any_p;
  logic [FRE_W-1:0] w_rep_fre;
  logic [FRE_W-1:0] w_fre_tgt;
  mmss_t            w_dec;

  // Edge-detection stage; tick, toggle and button presses are registered pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tick_q  <= 1'b0;
      r_tick    <= 1'b0;
      r_tog     <= 1'b0;
      r_set_q   <= 1'b0;
      r_start_q <= 1'b0;
      r_up_q    <= 1'b0;
      r_dn_q    <= 1'b0;
      r_set_p   <= 1'b0;
      r_start_p <= 1'b0;
      r_up_p    <= 1'b0;
      r_dn_p    <= 1'b0;
    end else begin
      r_tick_q  <= tick_clk;
      r_tick    <= tick_clk & ~r_tick_q;
      r_tog     <= tick_clk ^ r_tick_q;
      r_set_q   <= btn_set;
      r_start_q <= btn_start;
      r_up_q    <= btn_up;
      r_dn_q    <= btn_down;
      r_set_p   <= btn_set & ~r_set_q;
      r_start_p <= btn_start & ~r_start_q;
      r_up_p    <= btn_up & ~r_up_q;
      r_dn_p    <= btn_down & ~r_dn_q;
    end
  end

  // Both directions held cancel each other out
  assign w_held  = r_up_q ^ r_dn_q;
  assign w_any_p = r_set_p | r_start_p | r_up_p | r_dn_p;
  assign w_dec   = mmss_dec(r_time);

  btn_repeat u_rep (
    .clk       (clk),
    .rst       (rst),
    .i_en      (r_state == ST_SET),
    .i_held    (w_held),
    .i_press   (r_up_p | r_dn_p),
    .i_tick    (r_tick),
    .o_step_c  (w_step),
    .o_fre_tgt (w_rep_fre)
  );

  assign w_fre_tgt = ((r_state == ST_SET) && w_held) ? w_rep_fre : FRE_W'(FRE_RUN);

  // Mode FSM, time/preset update and divider rate register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_time  <= DEF_TIME;
      r_pre   <= DEF_TIME;
      r_alarm <= 1'b0;
      r_acnt  <= '0;
      r_fre   <= FRE_W'(FRE_RUN);
    end else begin
      // Rate changes only on a divider toggle so its counter is near zero
      if (r_tog) r_fre <= w_fre_tgt;
      case (r_state)
        ST_IDLE: begin
          if (r_set_p) r_state <= ST_SET;
          else if (r_start_p && !mmss_zero(r_time)) r_state <= ST_RUN;
        end
        ST_SET: begin
          if (r_set_p) begin
            r_state <= ST_IDLE;
            r_pre   <= r_time;
          end else if (w_step) begin
            r_time <= r_up_q ? mmss_inc(r_time) : w_dec;
          end
        end
        ST_RUN: begin
          if (r_start_p) begin
            r_state <= ST_PAUSE;
          end else if (r_tick) begin
            r_time <= w_dec;
            if (mmss_zero(w_dec)) begin
              r_state <= ST_ALARM;
              r_alarm <= 1'b1;
              r_acnt  <= '0;
            end
          end
        end
        ST_PAUSE: begin
          if (r_set_p) begin
            r_state <= ST_IDLE;
            r_time  <= r_pre;
          end else if (r_start_p) begin
            r_state <= ST_RUN;
          end
        end
        ST_ALARM: begin
          if (w_any_p || (r_tick && (r_acnt == ACNT_W'(ALARM_TICKS - 1)))) begin
            r_state <= ST_IDLE;
            r_time  <= r_pre;
            r_alarm <= 1'b0;
            r_acnt  <= '0;
          end else if (r_tick) begin
            r_acnt <= r_acnt + ACNT_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign fre   = r_fre;
  assign min   = r_time.mm;
  assign sec   = r_time.ss;
  assign state = r_state;
  assign alarm = r_alarm;

endmodule

// File: tb/tb_countdown_ctrl.sv
// Self-checking bench for countdown_ctrl. The model keeps the time as total
// seconds modulo 6000 and derives expected divider rates arithmetically.
module tb_countdown_ctrl;
  import countdown_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tick_clk = 1'b0;
  logic        btn_set = 1'b0, btn_start = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
  logic [25:0] fre;
  logic [6:0]  min;
  logic [5:0]  sec;
  logic [2:0]  state;
  logic        alarm;

  int n_vec = 0;
  int n_err = 0;
  int m_t, m_pre, m_st;
  int m_fre;

  always #5 clk = ~clk;

  countdown_ctrl dut (
    .clk(clk), .rst(rst), .tick_clk(tick_clk),
    .btn_set(btn_set), .btn_start(btn_start), .btn_up(btn_up), .btn_down(btn_down),
    .fre(fre), .min(min), .sec(sec), .state(state), .alarm(alarm)
  );

  function automatic int wrap(input int x);
    return ((x % 6000) + 6000) % 6000;
  endfunction

  // Expected {state, min, sec} from the model
  function automatic logic [15:0] ev();
    return {3'(m_st), 7'(m_t / 60), 6'(m_t % 60)};
  endfunction

  // Expected auto-repeat rate after n repeat steps
  function automatic int rep_rate(input int n);
    int v;
    v = 4 << (n / 8);
    return (v > 32) ? 32 : v;
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input int b, input logic v);
    case (b)
      0: btn_set = v;
      1: btn_start = v;
      2: btn_up = v;
      default: btn_down = v;
    endcase
  endtask

  task automatic press(input int b);
    drive(b, 1'b1); cyc(2);
    drive(b, 1'b0); cyc(2);
  endtask

  task automatic tick();
    tick_clk = 1'b1; cyc(2);
    tick_clk = 1'b0; cyc(2);
  endtask

  // Walks the time to target with single up/down presses (model tracks it)
  task automatic set_time(input int target);
    int d;
    while (m_t != target) begin
      d = wrap(target - m_t);
      if (d <= 3000) begin press(2); m_t = wrap(m_t + 1); end
      else begin press(3); m_t = wrap(m_t - 1); end
    end
  endtask

  task automatic test_reset();
    cyc(1); rst = 1'b1; cyc(2); rst = 1'b0; cyc(1);
    m_t = 300; m_pre = 300; m_st = int'(ST_IDLE);
    n_vec++; if ({state, min, sec} !== ev()) begin n_err++;
      $display("FAIL reset_time: got %h want %h", {state, min, sec}, ev()); end
    n_vec++; if (fre !== 26'd1 || alarm !== 1'b0) begin n_err++;
      $display("FAIL reset_fre_alarm: got fre=%0d alarm=%b want fre=1 alarm=0", fre, alarm); end
  endtask

  task automatic test_run_pause();
    int k;
    btn_start = 1'b1; cyc(1);
    n_vec++; if (state !== 3'(ST_IDLE)) begin n_err++;
      $display("FAIL start_latency1: got st=%0d want %0d", state, ST_IDLE); end
    cyc(1); m_st = int'(ST_RUN);
    n_vec++; if ({state, min, sec} !== ev()) begin n_err++;
      $display("FAIL start_latency2: got %h want %h", {state, min, sec}, ev()); end
    btn_start = 1'b0; cyc(2);
    tick_clk = 1'b1; cyc(1);
    n_vec++; if ({state, min, sec} !== ev()) begin n_err++;
      $display("FAIL tick_latency1: got %h want %h", {state, min, sec}, ev()); end
    cyc(1); m_t = m_t - 1;
    n_vec++; if ({state, min, sec} !== ev()) begin n_err++;
      $display("FAIL tick_latency2: got %h want %h", {state, min, sec}, ev()); end
    tick_clk = 1'b0; cyc(2);
    repeat (4) begin tick(); m_t = m_t - 1; end
    n_vec++; if ({state, min, sec} !== ev()) begin n_err++;
      $display("FAIL run_5ticks: got %h want %h", {state, min, sec}, ev()); end
    press(1); m_st = int'(ST_PAUSE);
    repeat (3) tick();
    n_vec++; if ({state, min, sec} !== ev()) begin n_err++;
      $display("FAIL pause_hold: got %h want %h", {state, min, sec}, ev()); end
    k = $urandom_range(1, 20);
    press(1); m_st = int'(ST_RUN);
    repeat (k) begin tick(); m_t = m_t - 1; end
    n_vec++; if ({state, min, sec} !== ev()) begin n_err++;
      $display("FAIL run_rand: got %h want %h", {state, min, sec}, ev()); end
    press(1); press(0); m_st = int'(ST_IDLE); m_t = m_pre;
    n_vec++; if ({state, min, sec} !== ev()) begin n_err++;
      $display("FAIL pause_reload: got %h want %h", {state, min, sec}, ev()); end
  endtask

  task automatic test_alarm();
    int b;
    press(0); m_st = int'(ST_SET);
    set_time(2);
    n_vec++; if ({state, min, sec} !== ev()) begin n_err++;
      $display("FAIL set_0002: got %h want %h", {state, min, sec}, ev()); end
    press(0); m_st = int'(ST_IDLE); m_pre = m_t;
    press(1); m_st = int'(ST_RUN);
    tick(); m_t = 1;
    tick(); m_t = 0; m_st = int'(ST_ALARM);
    n_vec++; if ({state, min, sec} !== ev() || alarm !== 1'b1) begin n_err++;
      $display("FAIL alarm_enter: got %h alarm=%b want %h alarm=1", {state, min, sec}, alarm, ev()); end
    repeat (29) tick();
    n_vec++; if ({state, min, sec} !== ev() || alarm !== 1'b1) begin n_err++;
      $display("FAIL alarm_29: got %h alarm=%b want %h alarm=1", {state, min, sec}, alarm, ev()); end
    tick(); m_st = int'(ST_IDLE); m_t = m_pre;
    n_vec++; if ({state, min, sec} !== ev() || alarm !== 1'b0) begin n_err++;
      $display("FAIL alarm_timeout: got %h alarm=%b want %h alarm=0", {state, min, sec}, alarm, ev()); end
    press(1); tick(); tick();
    b = $urandom_range(0, 3);
    press(b); m_st = int'(ST_IDLE); m_t = m_pre;
    n_vec++; if ({state, min, sec} !== ev() || alarm !== 1'b0) begin n_err++;
      $display("FAIL alarm_button%0d: got %h alarm=%b want %h alarm=0", b, {state, min, sec}, alarm, ev()); end
  endtask

  task automatic test_set_wrap();
    press(0); m_st = int'(ST_SET);
    set_time(0);
    press(3); m_t = 5999;
    n_vec++; if ({state, min, sec} !== ev()) begin n_err++;
      $display("FAIL wrap_down: got %h want %h", {state, min, sec}, ev()); end
    press(2); press(2); m_t = 1;
    n_vec++; if ({state, min, sec} !== ev()) begin n_err++;
      $display("FAIL wrap_up: got %h want %h", {state, min, sec}, ev()); end
    press(3); m_t = 0;
    press(0); m_st = int'(ST_IDLE); m_pre = 0;
    press(1);
    n_vec++; if ({state, min, sec} !== ev()) begin n_err++;
      $display("FAIL start_at_zero: got %h want %h", {state, min, sec}, ev()); end
  endtask

  task automatic test_random_set();
    int b;
    press(0); m_st = int'(ST_SET);
    set_time(59);
    press(2); m_t = 60;
    n_vec++; if ({state, min, sec} !== ev()) begin n_err++;
      $display("FAIL sec_carry: got %h want %h", {state, min, sec}, ev()); end
    press(3); m_t = 59;
    n_vec++; if ({state, min, sec} !== ev()) begin n_err++;
      $display("FAIL sec_borrow: got %h want %h", {state, min, sec}, ev()); end
    repeat (40) begin
      b = $urandom_range(2, 3);
      press(b);
      m_t = wrap(m_t + ((b == 2) ? 1 : -1));
      n_vec++; if ({state, min, sec} !== ev()) begin n_err++;
        $display("FAIL rand_step: got %h want %h", {state, min, sec}, ev()); end
    end
    press(0); m_st = int'(ST_IDLE); m_pre = m_t;
  endtask

  task automatic test_tick_start_same();
    press(0); m_st = int'(ST_SET);
    set_time(60);
    press(0); m_st = int'(ST_IDLE); m_pre = 60;
    press(1); m_st = int'(ST_RUN);
    tick_clk = 1'b1; btn_start = 1'b1; cyc(2); m_st = int'(ST_PAUSE);
    n_vec++; if ({state, min, sec} !== ev()) begin n_err++;
      $display("FAIL tick_start_same: got %h want %h", {state, min, sec}, ev()); end
    tick_clk = 1'b0; btn_start = 1'b0; cyc(2);
    tick();
    n_vec++; if ({state, min, sec} !== ev()) begin n_err++;
      $display("FAIL pause_after_same: got %h want %h", {state, min, sec}, ev()); end
  endtask

  task automatic test_hold_accel();
    int n, e;
    press(0); m_st = int'(ST_IDLE); m_t = m_pre;
    press(0); m_st = int'(ST_SET);
    btn_up = 1'b1; cyc(3); m_t = wrap(m_t + 1);
    n_vec++; if ({state, min, sec} !== ev() || fre !== 26'd1) begin n_err++;
      $display("FAIL hold_press: got %h fre=%0d want %h fre=1", {state, min, sec}, fre, ev()); end
    m_fre = 1; n = 0;
    for (int i = 0; i < 40; i++) begin
      tick_clk = ~tick_clk; cyc(1);
      n_vec++; if (fre !== 26'(m_fre)) begin n_err++;
        $display("FAIL fre_early_%0d: got %0d want %0d", i, fre, m_fre); end
      cyc(1);
      if (tick_clk) begin e = rep_rate(n); n++; m_t = wrap(m_t + 1); end
      else e = rep_rate(n);
      n_vec++; if (fre !== 26'(e)) begin n_err++;
        $display("FAIL fre_load_%0d: got %0d want %0d", i, fre, e); end
      m_fre = e; cyc(2);
      n_vec++; if (fre !== 26'(m_fre)) begin n_err++;
        $display("FAIL fre_stable_%0d: got %0d want %0d", i, fre, m_fre); end
    end
    n_vec++; if ({state, min, sec} !== ev()) begin n_err++;
      $display("FAIL hold_time: got %h want %h", {state, min, sec}, ev()); end
    btn_up = 1'b0; cyc(3);
    n_vec++; if (fre !== 26'(m_fre)) begin n_err++;
      $display("FAIL fre_release_hold: got %0d want %0d", fre, m_fre); end
    tick_clk = 1'b1; cyc(2);
    n_vec++; if (fre !== 26'd1 || {state, min, sec} !== ev()) begin n_err++;
      $display("FAIL fre_release_load: got fre=%0d %h want fre=1 %h", fre, {state, min, sec}, ev()); end
    tick_clk = 1'b0; cyc(2);
  endtask

  task automatic test_reset_midset();
    btn_up = 1'b1; cyc(3);
    tick(); tick();
    rst = 1'b1; #1;
    m_t = 300; m_pre = 300; m_st = int'(ST_IDLE);
    n_vec++; if ({state, min, sec} !== ev() || fre !== 26'd1 || alarm !== 1'b0) begin n_err++;
      $display("FAIL rst_midset: got %h fre=%0d alarm=%b want %h fre=1 alarm=0",
               {state, min, sec}, fre, alarm, ev()); end
    btn_up = 1'b0; cyc(2); rst = 1'b0; cyc(2);
    press(1); m_st = int'(ST_RUN);
    tick(); m_t = 299;
    n_vec++; if ({state, min, sec} !== ev()) begin n_err++;
      $display("FAIL post_rst_run: got %h want %h", {state, min, sec}, ev()); end
    press(1); press(0); m_st = int'(ST_IDLE); m_t = m_pre;
    n_vec++; if ({state, min, sec} !== ev()) begin n_err++;
      $display("FAIL preset_default: got %h want %h", {state, min, sec}, ev()); end
  endtask

  initial begin
    test_reset();
    test_run_pause();
    test_alarm();
    test_set_wrap();
    test_random_set();
    test_tick_start_same();
    test_hold_accel();
    test_reset_midset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
